// File: rtl/bus_pkg.sv
// Shared constants for the bus memory block: default bus widths and the
// control FSM state encoding.
package bus_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/ram_array.sv
// Single-port storage: synchronous write, registered read.
// Contents are never reset. Only the read register is reset.
module ram_array #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 256,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // write port; storage keeps its contents across reset
  always_ff @(posedge clock) begin
    if (en && we) mem[idx] <= wdata;
  end

  // read register holds its value until the next enabled read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          rdata <= '0;
    else if (en && !we)  rdata <= mem[idx];
  end

endmodule

// File: rtl/bus_memory.sv
// Bus-attached memory with a programmable number of wait states and a
// write-protected low region. The edge that enters DONE is the only edge
// where the array is written or read.
import bus_pkg::*;

module bus_memory #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 65536,
  parameter int WAIT_STATES = 0,
  parameter int ROM_TOP     = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              fault
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  localparam logic [ADDR_W:0] ROM_TOP_L = (ADDR_W+1)'(ROM_TOP);

  logic [1:0]        run_pipe;
  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] din_q;

  logic              start, fire, rom_hit;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [DATA_W-1:0] acc_din;

  // reset release runs through two flops before accesses may start
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) run_pipe <= '0;
    else        run_pipe <= {run_pipe[0], 1'b1};
  end

  assign start = (state == ST_IDLE) && run_pipe[1] && req;

  // With zero wait states DONE is entered on the sampling edge itself, so the
  // access uses the live inputs there; otherwise it uses the latched copy.
  assign acc_addr = (state == ST_IDLE) ? address  : addr_q;
  assign acc_we   = (state == ST_IDLE) ? write_en : we_q;
  assign acc_din  = (state == ST_IDLE) ? data_in  : din_q;

  assign fire    = (start && (WAIT_STATES == 0)) ||
                   ((state == ST_WAIT) && req && (cnt == 4'd0));
  assign rom_hit = {1'b0, acc_addr} < ROM_TOP_L;

  // control FSM, request latch and the ready/fault pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      ready <= fire;
      fault <= fire && acc_we && rom_hit;
      case (state)
        ST_IDLE: if (start) begin
          addr_q <= address;
          we_q   <= write_en;
          din_q  <= data_in;
          if (WAIT_STATES == 0) begin
            state <= ST_DONE;
          end else begin
            state <= ST_WAIT;
            cnt   <= WS_LOAD;
          end
        end
        ST_WAIT: begin
          if (!req)              state <= ST_IDLE;
          else if (cnt == 4'd0)  state <= ST_DONE;
          else                   cnt   <= cnt - 4'd1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  ram_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clock (clock),
    .reset (reset),
    .en    (fire && !(acc_we && rom_hit)),
    .we    (acc_we),
    .idx   (acc_addr[IDX_W-1:0]),
    .wdata (acc_din),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_bus_memory.sv
// Directed bench for bus_memory: three instances cover zero wait states with
// a protected low region, three wait states with a 256-word array, and five
// wait states for abort and reset-during-access cases.
module tb_bus_memory;

  logic       clock;
  logic       reset;
  logic [2:0] req;
  logic       write_en;
  logic [15:0] address;
  logic [7:0] data_in;
  logic [7:0] dout [3];
  logic [2:0] rdy, flt;

  int checks = 0;
  int failures = 0;

  bus_memory #(.WAIT_STATES(0), .ROM_TOP(16'h0100)) dut0 (
    .clock(clock), .reset(reset), .req(req[0]), .write_en(write_en),
    .address(address), .data_in(data_in), .data_out(dout[0]),
    .ready(rdy[0]), .fault(flt[0]));

  bus_memory #(.WAIT_STATES(3), .DEPTH(256)) dut1 (
    .clock(clock), .reset(reset), .req(req[1]), .write_en(write_en),
    .address(address), .data_in(data_in), .data_out(dout[1]),
    .ready(rdy[1]), .fault(flt[1]));

  bus_memory #(.WAIT_STATES(5)) dut2 (
    .clock(clock), .reset(reset), .req(req[2]), .write_en(write_en),
    .address(address), .data_in(data_in), .data_out(dout[2]),
    .ready(rdy[2]), .fault(flt[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // one access on instance d; inputs are scrambled right after the sampling
  // edge so a design that does not latch them gets caught
  task automatic access(input int d, input logic we, input logic [15:0] a,
                        input logic [7:0] din, input int exp_n,
                        input logic exp_fault, input string tag);
    int n;
    logic seen;
    n = 0; seen = 1'b0;
    write_en = we; address = a; data_in = din; req[d] = 1'b1;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        address = ~a; data_in = ~din; write_en = ~we;
      end
      if (rdy[d]) seen = 1'b1;
    end
    req[d] = 1'b0;
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_fault"}, flt[d], exp_fault);
    tick();
    chk({tag, "_pulse"}, rdy[d], 1'b0);
  endtask

  initial begin
    int n;
    logic seen;
    reset = 1'b0; req = '0; write_en = 1'b0; address = '0; data_in = '0;
    dut0.u_ram.mem[16'h00FF] = 8'h42;
    #2;
    chk("rst_ready", rdy, 3'b000);
    chk("rst_fault", flt, 3'b000);
    chk("rst_dout0", dout[0], 8'h00);
    tick(); tick();
    reset = 1'b1;
    // request held from release: must not complete before the second edge
    write_en = 1'b0; address = 16'h00FF; req[0] = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      tick(); n++;
      if (rdy[0]) seen = 1'b1;
    end
    req[0] = 1'b0;
    chk("sync_release", (seen && n >= 2), 1'b1);
    chk("preload_rd", dout[0], 8'h42);
    tick();

    access(0, 1'b1, 16'h1234, 8'hA5, 1, 1'b0, "w1234");
    access(0, 1'b0, 16'h1234, 8'h00, 1, 1'b0, "r1234");
    chk("r1234_data", dout[0], 8'hA5);

    access(0, 1'b1, 16'h00FF, 8'h55, 1, 1'b1, "rom_w");
    chk("rom_w_hold", dout[0], 8'hA5);
    access(0, 1'b0, 16'h00FF, 8'h00, 1, 1'b0, "rom_r");
    chk("rom_r_data", dout[0], 8'h42);
    access(0, 1'b1, 16'h0100, 8'h66, 1, 1'b0, "ram_w");
    access(0, 1'b0, 16'h0100, 8'h00, 1, 1'b0, "ram_r");
    chk("ram_r_data", dout[0], 8'h66);

    access(1, 1'b0, 16'h0010, 8'h00, 4, 1'b0, "ws3_r");
    access(1, 1'b1, 16'h0105, 8'h3C, 4, 1'b0, "alias_w");
    access(1, 1'b0, 16'h0005, 8'h00, 4, 1'b0, "alias_r");
    chk("alias_data", dout[1], 8'h3C);

    // back-to-back reads with req held: ready pulses WAIT_STATES+2 apart
    write_en = 1'b0; address = 16'h0005; req[1] = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      tick(); n++;
      if (rdy[1]) seen = 1'b1;
    end
    chk("b2b_first", seen, 1'b1);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      tick(); n++;
      if (rdy[1]) seen = 1'b1;
    end
    req[1] = 1'b0;
    chk("b2b_interval", n, 5);
    tick(); tick();

    access(2, 1'b1, 16'h2000, 8'h11, 6, 1'b0, "ws5_w");
    access(2, 1'b0, 16'h2000, 8'h00, 6, 1'b0, "ws5_r");
    chk("ws5_data", dout[2], 8'h11);

    // abort: req dropped in the second WAIT cycle
    write_en = 1'b1; address = 16'h2000; data_in = 8'h77; req[2] = 1'b1;
    tick(); tick();
    req[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rdy[2]) seen = 1'b1;
    end
    chk("abort_noready", seen, 1'b0);
    chk("abort_dout", dout[2], 8'h11);
    access(2, 1'b0, 16'h2000, 8'h00, 6, 1'b0, "abort_r");
    chk("abort_data", dout[2], 8'h11);

    // reset in the second WAIT cycle
    write_en = 1'b1; address = 16'h2000; data_in = 8'h77; req[2] = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_ready", rdy[2], 1'b0);
    chk("rst_mid_dout", dout[2], 8'h00);
    chk("rst_mid_dout0", dout[0], 8'h00);
    req[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rdy[2]) seen = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rdy[2]) seen = 1'b1;
    end
    chk("rst_mid_noready", seen, 1'b0);
    access(2, 1'b0, 16'h2000, 8'h00, 6, 1'b0, "rst_r");
    chk("rst_data", dout[2], 8'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
